// File: rtl/console_pkg.sv
// Shared constants for the console input device: register indices and bit positions.
package console_pkg;
  typedef enum logic [1:0] {
    REG_RXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_idx_e;

  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVF       = 18;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_OVF_CLR = 1;
endpackage

// File: rtl/console_rx_sync_fifo.sv
// Synchronous FIFO with flush; a pop on a full FIFO frees the slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_nxt_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop, do_push;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign rdata_o     = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (!flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/console_rx.sv
// Wishbone console input: host bytes queue in a FIFO, the CPU polls and pops them.
module console_rx
  import console_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_irq
);
  logic             rd_en, wr_ctrl, pop, flush, ovf_clr, ovf_set;
  logic             ovf_q, ovf_d, ack_q, irq_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       head;
  logic [CNT_W-1:0] count, count_nxt;
  logic             empty, full;
  logic             unused_wdata;

  assign unused_wdata = ^i_wb_data[31:2];

  assign rd_en   = i_wb_stb && !i_wb_we;
  assign wr_ctrl = i_wb_stb && i_wb_we && (reg_idx_e'(i_wb_addr) == REG_CTRL);
  assign pop     = rd_en && (reg_idx_e'(i_wb_addr) == REG_RXDATA) && !empty;
  assign flush   = wr_ctrl && i_wb_data[CTRL_FLUSH];
  assign ovf_clr = wr_ctrl && i_wb_data[CTRL_OVF_CLR];
  // A byte is lost only when full with no same-cycle pop; a flush discards it silently.
  assign ovf_set = i_rx_valid && !flush && full && !pop;
  assign ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .push_i      (i_rx_valid),
    .pop_i       (pop),
    .flush_i     (flush),
    .wdata_i     (i_rx_data),
    .rdata_o     (head),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .empty_o     (empty),
    .full_o      (full)
  );

  // STATUS shows pre-update state; RXDATA read while empty returns 0.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (reg_idx_e'(i_wb_addr))
        REG_RXDATA: if (!empty) rdata_d = {23'b0, 1'b1, head};
        REG_STATUS: begin
          rdata_d[CNT_W-1:0] = count;
          rdata_d[ST_EMPTY]  = empty;
          rdata_d[ST_FULL]   = full;
          rdata_d[ST_OVF]    = ovf_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= i_wb_stb;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      irq_q   <= (count_nxt != '0);
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;
  assign o_irq      = irq_q;
endmodule
